model_config_ctx_mem: RTL and testbench
=======================================

MODEL_CONFIG_CTX_MEM -- requirements
Module: model_config_ctx_mem

Interface
REQ-001 SHALL have parameter NUM_CTX, default 2: number of independent model contexts.
REQ-002 SHALL have parameter MAX_LAYERS, default 32 (power of 2, 2..256): entries per table.
REQ-003 SHALL have parameter DATA_W, default 32: data word width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk_i  input  1  rising-edge clock.
REQ-006 SHALL have port rst_ni  input  1  async active-low reset.
REQ-007 SHALL have ports config_valid_i input 1, config_ready_o output 1, config_addr_i input 32, config_data_i input DATA_W: write channel.
REQ-008 SHALL have ports model_read_valid_i input 1, model_read_ready_o output 1, model_addr_i input 32: read request.
REQ-009 SHALL have ports model_data_o output DATA_W, model_data_valid_o output 1: read response.
REQ-010 SHALL have port busy_o  output 1  recompute engine active.

Function
REQ-011 SHALL decode addresses as: [15:12] context, [10:8] region, [7:0] index; context >= NUM_CTX or index >= MAX_LAYERS is unmapped.
REQ-012 SHALL implement regions: 0 PARAMS, 1 FORWARD_SPARSITY, 2 BACKWARD_SPARSITY (writable); 3 INTERMEDIATE_MEM, 4 FORWARD_COMPUTE, 5 BACKWARD_COMPUTE (read-only); 6-7 unmapped.
REQ-013 SHALL map PARAMS indices: 0 model type, 1 batch, 2 forward length, 3 backward length, 4 seq length, 5 attention heads, 6 hidden dim, 31 COMMIT (write-only trigger, reads 0).
REQ-014 SHALL accept a write when config_valid_i && config_ready_o; config_ready_o = !busy_o.
REQ-015 SHALL silently drop writes to read-only or unmapped addresses.
REQ-016 SHALL start recompute for the addressed context on an accepted write to PARAMS index 31; data value ignored.
REQ-017 SHALL run FSM IDLE -> BASE_A (p = batch*seq) -> BASE_B (base = p*hidden) -> CALC (one layer per cycle, i = 0..MAX_LAYERS-1) -> DONE -> IDLE; busy_o high in all non-IDLE states, i.e. MAX_LAYERS+3 cycles, rising the cycle after the COMMIT is accepted.
REQ-018 SHALL compute in CALC, with sf = min(fwd_sparsity[i],100), sb = min(bwd_sparsity[i],100), Lf/Lb = forward/backward length clamped to MAX_LAYERS: intermediate[i] = base if i<Lf else 0; forward_compute[i] = base*(100-sf) if i<Lf else 0; backward_compute[i] = 2*base*(100-sb) if i<Lb else 0.
REQ-019 SHALL truncate all products to DATA_W bits, unsigned.
REQ-020 SHALL use at most two multipliers in CALC.
REQ-021 SHALL accept a read when model_read_valid_i && model_read_ready_o; model_read_ready_o = 0 only while busy_o and the request targets region 3-5 of the context being recomputed.
REQ-022 SHALL assert model_data_valid_o for exactly one cycle, one cycle after read acceptance, with model_data_o valid that cycle; back-to-back reads sustain one per cycle.
REQ-023 SHALL return 0 for unmapped reads and PARAMS index 31, and hold model_data_o when not valid.
REQ-024 SHALL read derived regions as 0 for a context never committed.
REQ-025 SHALL leave other contexts' tables unaffected and readable during a recompute.

Reset
REQ-026 SHALL, on rst_ni low, clear all tables of all contexts, abort any recompute (FSM to IDLE), and drive busy_o=0, model_data_valid_o=0, model_data_o=0, config_ready_o=1, model_read_ready_o=1.

Verification
REQ-027 SHALL cover: ctx0 batch=4, seq=2, hidden=64, fwd len=12, fwd sparsity[3]=15, COMMIT -> busy_o high 35 cycles (MAX_LAYERS=32); FORWARD_COMPUTE[0]=51200, [3]=43520, [12]=0; INTERMEDIATE[11]=512.
REQ-028 SHALL cover: ctx0 bwd len=9, bwd sparsity[6]=66, COMMIT -> BACKWARD_COMPUTE[6]=34816, [0]=102400, [9]=0.
REQ-029 SHALL cover: sparsity=150 clamps to 100 -> compute entry 0; forward length 40 -> clamped to 32.
REQ-030 SHALL cover: during ctx0 recompute, config write -> not accepted; read ctx0 region 4 -> ready 0; read ctx1 region 4 -> accepted, data one cycle later.
REQ-031 SHALL cover: rst_ni low mid-CALC -> busy_o 0 immediately, all reads return 0 afterwards.
REQ-032 SHALL cover: read ctx 3 (NUM_CTX=2) or region 7 -> model_data_valid_o pulse with data 0.

Source files
------------

// File: rtl/model_config_ctx_mem_if.sv
// Bus interface for model_config_ctx_mem.
// Groups the configuration write channel, the model read request/response
// channel and the recompute busy flag.
//   slave  : the memory block (consumes requests, drives ready/data/busy)
//   master : the host side (drives requests, observes ready/data/busy)
interface model_config_ctx_mem_if #(
  parameter int DATA_W = 32
);
  // configuration write channel
  logic              config_valid_i;
  logic              config_ready_o;
  logic [31:0]       config_addr_i;
  logic [DATA_W-1:0] config_data_i;
  // model read request
  logic              model_read_valid_i;
  logic              model_read_ready_o;
  logic [31:0]       model_addr_i;
  // model read response
  logic [DATA_W-1:0] model_data_o;
  logic              model_data_valid_o;
  // recompute engine active
  logic              busy_o;

  modport slave (
    input  config_valid_i, config_addr_i, config_data_i,
    input  model_read_valid_i, model_addr_i,
    output config_ready_o, model_read_ready_o,
    output model_data_o, model_data_valid_o, busy_o
  );

  modport master (
    output config_valid_i, config_addr_i, config_data_i,
    output model_read_valid_i, model_addr_i,
    input  config_ready_o, model_read_ready_o,
    input  model_data_o, model_data_valid_o, busy_o
  );
endinterface

// File: rtl/model_config_ctx_mem.sv
// Per-context model configuration memory with a derived-table recompute engine.
// Address map: [15:12] context, [10:8] region, [7:0] index.
//   region 0 PARAMS (0 type,1 batch,2 fwd len,3 bwd len,4 seq,5 heads,6 hidden,
//            31 COMMIT), 1 fwd sparsity, 2 bwd sparsity  : read/write
//   region 3 intermediate, 4 fwd compute, 5 bwd compute : read-only (derived)
// A write to PARAMS[31] launches a recompute of that context's derived tables.
// Ports:
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset (clears every table)
//   bus    : slave modport carrying the write channel, read request/response
//            and busy_o
module model_config_ctx_mem #(
  parameter int NUM_CTX    = 2,
  parameter int MAX_LAYERS = 32,
  parameter int DATA_W     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  model_config_ctx_mem_if.slave  bus
);

  localparam int CW = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
  localparam int IW = $clog2(MAX_LAYERS);
  localparam logic [DATA_W-1:0] PCT_MAX = DATA_W'(100);

  typedef enum logic [2:0] {
    S_IDLE, S_BASE_A, S_BASE_B, S_CALC, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     ctx_q, ctx_d;
  logic [IW-1:0]     i_q, i_d;
  logic [DATA_W-1:0] p_q, p_d, base_q, base_d;
  logic              calc_we;

  logic [DATA_W-1:0] params_q [NUM_CTX][7];
  logic [DATA_W-1:0] fsp_q    [NUM_CTX][MAX_LAYERS];
  logic [DATA_W-1:0] bsp_q    [NUM_CTX][MAX_LAYERS];
  logic [DATA_W-1:0] inter_q  [NUM_CTX][MAX_LAYERS];
  logic [DATA_W-1:0] fcomp_q  [NUM_CTX][MAX_LAYERS];
  logic [DATA_W-1:0] bcomp_q  [NUM_CTX][MAX_LAYERS];

  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  logic busy;
  assign busy = (state_q != S_IDLE);

  // ---------------- write decode ----------------
  logic [3:0]    wr_ctx_f;
  logic [2:0]    wr_region;
  logic [7:0]    wr_idx;
  logic [CW-1:0] wr_c;
  logic [IW-1:0] wr_i;
  logic          wr_mapped, wr_fire, commit;

  assign wr_ctx_f  = bus.config_addr_i[15:12];
  assign wr_region = bus.config_addr_i[10:8];
  assign wr_idx    = bus.config_addr_i[7:0];
  assign wr_c      = bus.config_addr_i[12 +: CW];
  assign wr_i      = bus.config_addr_i[0 +: IW];
  assign wr_mapped = (32'(wr_ctx_f) < 32'(NUM_CTX)) && (32'(wr_idx) < 32'(MAX_LAYERS));
  assign wr_fire   = bus.config_valid_i && !busy;
  assign commit    = wr_fire && wr_mapped && (wr_region == 3'd0) && (wr_idx == 8'd31);

  // ---------------- read decode ----------------
  logic [3:0]        rd_ctx_f;
  logic [2:0]        rd_region;
  logic [7:0]        rd_idx;
  logic [CW-1:0]     rd_c;
  logic [IW-1:0]     rd_i;
  logic              rd_mapped, rd_blocked, rd_fire;
  logic [DATA_W-1:0] rd_val;

  assign rd_ctx_f   = bus.model_addr_i[15:12];
  assign rd_region  = bus.model_addr_i[10:8];
  assign rd_idx     = bus.model_addr_i[7:0];
  assign rd_c       = bus.model_addr_i[12 +: CW];
  assign rd_i       = bus.model_addr_i[0 +: IW];
  assign rd_mapped  = (32'(rd_ctx_f) < 32'(NUM_CTX)) && (32'(rd_idx) < 32'(MAX_LAYERS));
  // Only the derived tables of the context under recompute are stalled.
  assign rd_blocked = busy && (rd_region >= 3'd3) && (rd_region <= 3'd5) &&
                      (32'(rd_ctx_f) == 32'(ctx_q));
  assign rd_fire    = bus.model_read_valid_i && !rd_blocked;

  always_comb begin
    rd_val = '0;
    if (rd_mapped) begin
      case (rd_region)
        3'd0:    if (rd_idx < 8'd7) rd_val = params_q[rd_c][rd_idx[2:0]];
        3'd1:    rd_val = fsp_q[rd_c][rd_i];
        3'd2:    rd_val = bsp_q[rd_c][rd_i];
        3'd3:    rd_val = inter_q[rd_c][rd_i];
        3'd4:    rd_val = fcomp_q[rd_c][rd_i];
        3'd5:    rd_val = bcomp_q[rd_c][rd_i];
        default: rd_val = '0;
      endcase
    end
  end

  // ---------------- datapath: two shared multipliers ----------------
  logic [DATA_W-1:0] cur_fsp, cur_bsp, sf, sb;
  logic [DATA_W-1:0] ma_x, ma_y, mb_x, mb_y, mul_a, mul_b;
  logic              in_f, in_b;

  always_comb begin
    cur_fsp = fsp_q[ctx_q][i_q];
    cur_bsp = bsp_q[ctx_q][i_q];
    sf      = (cur_fsp > PCT_MAX) ? PCT_MAX : cur_fsp;
    sb      = (cur_bsp > PCT_MAX) ? PCT_MAX : cur_bsp;
    ma_x    = params_q[ctx_q][1];
    ma_y    = params_q[ctx_q][4];
    mb_x    = '0;
    mb_y    = '0;
    case (state_q)
      S_BASE_B: begin
        ma_x = p_q;
        ma_y = params_q[ctx_q][6];
      end
      S_CALC: begin
        ma_x = base_q;
        ma_y = PCT_MAX - sf;
        mb_x = base_q;
        mb_y = PCT_MAX - sb;
      end
      default: ;
    endcase
  end

  assign mul_a = ma_x * ma_y;
  assign mul_b = mb_x * mb_y;
  // i never reaches MAX_LAYERS, so comparing against the raw length is the
  // same as comparing against the length clamped to MAX_LAYERS.
  assign in_f  = DATA_W'(i_q) < params_q[ctx_q][2];
  assign in_b  = DATA_W'(i_q) < params_q[ctx_q][3];

  // ---------------- recompute FSM ----------------
  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    i_d     = i_q;
    p_d     = p_q;
    base_d  = base_q;
    calc_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (commit) begin
          state_d = S_BASE_A;
          ctx_d   = wr_c;
          i_d     = '0;
        end
      end
      S_BASE_A: begin
        p_d     = mul_a;
        state_d = S_BASE_B;
      end
      S_BASE_B: begin
        base_d  = mul_a;
        state_d = S_CALC;
      end
      S_CALC: begin
        calc_we = 1'b1;
        if (i_q == IW'(MAX_LAYERS - 1)) state_d = S_DONE;
        else                            i_d     = i_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ctx_q   <= '0;
      i_q     <= '0;
      p_q     <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
      i_q     <= i_d;
      p_q     <= p_d;
      base_q  <= base_d;
    end
  end

  // ---------------- tables ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NUM_CTX; c++) begin
        for (int unsigned k = 0; k < 7; k++) params_q[CW'(c)][3'(k)] <= '0;
        for (int unsigned k = 0; k < MAX_LAYERS; k++) begin
          fsp_q[CW'(c)][IW'(k)]   <= '0;
          bsp_q[CW'(c)][IW'(k)]   <= '0;
          inter_q[CW'(c)][IW'(k)] <= '0;
          fcomp_q[CW'(c)][IW'(k)] <= '0;
          bcomp_q[CW'(c)][IW'(k)] <= '0;
        end
      end
    end else begin
      if (wr_fire && wr_mapped) begin
        case (wr_region)
          3'd0:    if (wr_idx < 8'd7) params_q[wr_c][wr_idx[2:0]] <= bus.config_data_i;
          3'd1:    fsp_q[wr_c][wr_i] <= bus.config_data_i;
          3'd2:    bsp_q[wr_c][wr_i] <= bus.config_data_i;
          default: ;
        endcase
      end
      if (calc_we) begin
        inter_q[ctx_q][i_q] <= in_f ? base_q : '0;
        fcomp_q[ctx_q][i_q] <= in_f ? mul_a : '0;
        bcomp_q[ctx_q][i_q] <= in_b ? {mul_b[DATA_W-2:0], 1'b0} : '0;
      end
    end
  end

  // ---------------- read response ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_fire;
      if (rd_fire) rdata_q <= rd_val;
    end
  end

  assign bus.config_ready_o     = !busy;
  assign bus.model_read_ready_o = !rd_blocked;
  assign bus.model_data_o       = rdata_q;
  assign bus.model_data_valid_o = rvalid_q;
  assign bus.busy_o             = busy;

  logic unused_bits;
  assign unused_bits = ^{bus.config_addr_i[31:16], bus.config_addr_i[11],
                         bus.model_addr_i[31:16], bus.model_addr_i[11],
                         mul_b[DATA_W-1]};

endmodule

// File: tb/tb_model_config_ctx_mem.sv
module tb_model_config_ctx_mem;
  localparam int NUM_CTX    = 2;
  localparam int MAX_LAYERS = 32;
  localparam int DATA_W     = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  model_config_ctx_mem_if #(.DATA_W(DATA_W)) bus ();

  model_config_ctx_mem #(
    .NUM_CTX(NUM_CTX),
    .MAX_LAYERS(MAX_LAYERS),
    .DATA_W(DATA_W)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0]       addr;
    logic [DATA_W-1:0] exp;
    string             name;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] last_exp = '0;
  int run_len  = 0;
  int last_run = 0;

  function automatic logic [31:0] A(int c, int r, int i);
    return {16'h0, 4'(c), 1'b0, 3'(r), 8'(i)};
  endfunction

  function automatic void add(string n, logic [31:0] a, logic [DATA_W-1:0] e);
    vec_t v;
    v.addr = a; v.exp = e; v.name = n;
    vecs.push_back(v);
  endfunction

  task automatic check(string n, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // Scoreboard: every response is matched against the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && bus.model_data_valid_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got data %0d expected no response", bus.model_data_o);
      end else begin
        vec_t v;
        v = sb_q.pop_front();
        check(v.name, bus.model_data_o, v.exp);
        last_exp = v.exp;
      end
    end
  end

  // Length of the most recent completed busy stretch.
  always @(negedge clk) begin
    if (bus.busy_o) run_len <= run_len + 1;
    else if (run_len != 0) begin
      last_run <= run_len;
      run_len  <= 0;
    end
  end

  task automatic cfg_write(logic [31:0] a, logic [DATA_W-1:0] d);
    int n;
    @(posedge clk); #1;
    bus.config_valid_i = 1'b1;
    bus.config_addr_i  = a;
    bus.config_data_i  = d;
    n = 0;
    @(negedge clk);
    while (!bus.config_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.config_ready_o) begin
      checks++;
      failures++;
      $display("FAIL cfg_timeout: ready stuck at 0 expected 1");
    end
    @(posedge clk); #1;
    bus.config_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy_o) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout: busy stuck at 1 expected 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic run_reads(int lo, int hi);
    for (int k = lo; k < hi; k++) begin
      @(posedge clk); #1;
      bus.model_read_valid_i = 1'b1;
      bus.model_addr_i       = vecs[k].addr;
      @(negedge clk);
      if (bus.model_read_ready_o) sb_q.push_back(vecs[k]);
      else begin
        checks++;
        failures++;
        $display("FAIL %s_ready: got 0 expected 1", vecs[k].name);
      end
    end
    @(posedge clk); #1;
    bus.model_read_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", DATA_W'(sb_q.size()), '0);
    check("valid_one_cycle", DATA_W'(bus.model_data_valid_o), '0);
    check("data_hold", bus.model_data_o, last_exp);
  endtask

  int p0, pa, pb, pc, pd;

  initial begin
    vec_t v;
    // ---- vector tables ----
    add("pre_fwd0",   A(0,4,0), 0);
    add("pre_par1",   A(0,0,1), 4);
    add("pre_fsp3",   A(0,1,3), 15);
    add("ro_drop",    A(1,4,0), 0);
    add("pre_inter0", A(0,3,0), 0);
    p0 = vecs.size();
    add("fwd0",       A(0,4,0), 51200);
    add("fwd3",       A(0,4,3), 43520);
    add("fwd11",      A(0,4,11), 51200);
    add("fwd12",      A(0,4,12), 0);
    add("inter11",    A(0,3,11), 512);
    add("inter12",    A(0,3,12), 0);
    add("bwd0_len0",  A(0,5,0), 0);
    add("par31",      A(0,0,31), 0);
    add("par1_kept",  A(0,0,1), 4);
    add("par6",       A(0,0,6), 64);
    add("par0",       A(0,0,0), 7);
    add("ctx3",       A(3,0,1), 0);
    add("region7",    A(0,7,0), 0);
    add("idx40",      A(0,0,40), 0);
    add("ctx1_fwd0",  A(1,4,0), 0);
    pa = vecs.size();
    add("bwd6",       A(0,5,6), 34816);
    add("bwd0",       A(0,5,0), 102400);
    add("bwd8",       A(0,5,8), 102400);
    add("bwd9",       A(0,5,9), 0);
    add("fwd3_b",     A(0,4,3), 43520);
    pb = vecs.size();
    add("fwd5_clamp", A(0,4,5), 0);
    add("fwd31",      A(0,4,31), 51200);
    add("inter31",    A(0,3,31), 512);
    add("fwd12_c",    A(0,4,12), 51200);
    add("fwd3_c",     A(0,4,3), 43520);
    add("bwd6_c",     A(0,5,6), 34816);
    add("par2_raw",   A(0,0,2), 40);
    pc = vecs.size();
    add("rst_fwd0",   A(0,4,0), 0);
    add("rst_par1",   A(0,0,1), 0);
    add("rst_inter11",A(0,3,11), 0);
    add("rst_bwd0",   A(0,5,0), 0);
    add("rst_fsp3",   A(0,1,3), 0);
    add("rst_par6",   A(0,0,6), 0);
    pd = vecs.size();

    bus.config_valid_i     = 1'b0;
    bus.config_addr_i      = '0;
    bus.config_data_i      = '0;
    bus.model_read_valid_i = 1'b0;
    bus.model_addr_i       = '0;

    // ---- reset ----
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",    DATA_W'(bus.busy_o), 0);
    check("rst_valid",   DATA_W'(bus.model_data_valid_o), 0);
    check("rst_data",    bus.model_data_o, 0);
    check("rst_cfg_rdy", DATA_W'(bus.config_ready_o), 1);
    check("rst_rd_rdy",  DATA_W'(bus.model_read_ready_o), 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- configure ctx0 ----
    cfg_write(A(0,0,0), 7);
    cfg_write(A(0,0,1), 4);
    cfg_write(A(0,0,4), 2);
    cfg_write(A(0,0,6), 64);
    cfg_write(A(0,0,2), 12);
    cfg_write(A(0,1,3), 15);
    cfg_write(A(1,4,0), 55);   // read-only: dropped
    cfg_write(A(3,0,1), 9);    // unmapped context: dropped
    run_reads(0, p0);

    // ---- commit ctx0, probe the busy window ----
    cfg_write(A(0,0,31), 32'hDEAD);
    bus.config_valid_i     = 1'b1;
    bus.config_addr_i      = A(0,0,1);
    bus.config_data_i      = 99;
    bus.model_read_valid_i = 1'b1;
    bus.model_addr_i       = A(0,4,0);
    @(negedge clk);
    check("busy_rise",       DATA_W'(bus.busy_o), 1);
    check("busy_cfg_rdy",    DATA_W'(bus.config_ready_o), 0);
    check("busy_rd_blocked", DATA_W'(bus.model_read_ready_o), 0);
    @(posedge clk); #1;
    bus.config_valid_i = 1'b0;
    bus.model_addr_i   = A(1,4,0);
    @(negedge clk);
    check("busy_other_rdy", DATA_W'(bus.model_read_ready_o), 1);
    if (bus.model_read_ready_o) begin
      v.addr = A(1,4,0); v.exp = 0; v.name = "busy_other_data";
      sb_q.push_back(v);
    end
    @(posedge clk); #1;
    bus.model_read_valid_i = 1'b0;
    @(negedge clk);
    check("busy_other_valid", DATA_W'(bus.model_data_valid_o), 1);
    wait_idle();
    check("busy_len1", DATA_W'(last_run), DATA_W'(MAX_LAYERS + 3));
    run_reads(p0, pa);

    // ---- backward length and sparsity ----
    cfg_write(A(0,0,3), 9);
    cfg_write(A(0,2,6), 66);
    cfg_write(A(0,0,31), 0);
    wait_idle();
    check("busy_len2", DATA_W'(last_run), DATA_W'(MAX_LAYERS + 3));
    run_reads(pa, pb);

    // ---- clamping ----
    cfg_write(A(0,1,5), 150);
    cfg_write(A(0,0,2), 40);
    cfg_write(A(0,0,31), 0);
    wait_idle();
    run_reads(pb, pc);

    // ---- reset mid-CALC ----
    cfg_write(A(0,0,31), 0);
    repeat (10) @(negedge clk);
    check("calc_busy", DATA_W'(bus.busy_o), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",    DATA_W'(bus.busy_o), 0);
    check("midrst_valid",   DATA_W'(bus.model_data_valid_o), 0);
    check("midrst_cfg_rdy", DATA_W'(bus.config_ready_o), 1);
    check("midrst_rd_rdy",  DATA_W'(bus.model_read_ready_o), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_exp = '0;
    run_reads(pc, pd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
